unsat_clause_random_selector: RTL and testbench

//  Sequential successor to the combinational unsatisfied-clause tree: picks one unsatisfied clause uniformly at random.

---
 rtl/unsat_clause_random_selector_if.sv | 49 ++++
 rtl/unsat_clause_random_selector.sv | 162 ++++++++++++++++
 tb/tb_unsat_clause_random_selector.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/unsat_clause_random_selector_if.sv
// Bundle of request, seed and result signals between the clause checker bank,
// the random unsatisfied-clause selector and the move-proposal consumer.
interface unsat_clause_random_selector_if #(
    parameter int CLAUSE_INDEX_WIDTH   = 3,
    parameter int INT_COEFF_WIDTH      = 4,
    parameter int INT_VAR_INDEX_WIDTH  = 1,
    parameter int BOOL_VAR_INDEX_WIDTH = 1,
    parameter int LFSR_WIDTH           = 24
);
    localparam int N      = 1 << CLAUSE_INDEX_WIDTH;
    localparam int INT_W  = ((1 << INT_VAR_INDEX_WIDTH) + 1) * INT_COEFF_WIDTH;
    localparam int BOOL_W = 2 * (1 << BOOL_VAR_INDEX_WIDTH);

    logic                            in_start;
    logic                            in_all_checkers_ready;
    logic [N-1:0]                    in_clause_satisfied;
    logic [N*INT_W-1:0]              in_clause_coefficients_integer;
    logic [N*BOOL_W-1:0]             in_clause_coefficients_boolean;
    logic                            in_seed_load;
    logic [LFSR_WIDTH-1:0]           in_seed;
    logic                            in_out_ready;
    logic                            out_valid;
    logic                            out_busy;
    logic                            out_all_satisfied;
    logic [CLAUSE_INDEX_WIDTH:0]     out_unsat_count;
    logic [CLAUSE_INDEX_WIDTH-1:0]   out_clause_index;
    logic [INT_W-1:0]                out_clause_coefficients_integer;
    logic [BOOL_W-1:0]               out_clause_coefficients_boolean;

    // Requester / consumer side
    modport master (
        output in_start, in_all_checkers_ready, in_clause_satisfied,
               in_clause_coefficients_integer, in_clause_coefficients_boolean,
               in_seed_load, in_seed, in_out_ready,
        input  out_valid, out_busy, out_all_satisfied, out_unsat_count,
               out_clause_index, out_clause_coefficients_integer,
               out_clause_coefficients_boolean
    );

    // Selector side
    modport slave (
        input  in_start, in_all_checkers_ready, in_clause_satisfied,
               in_clause_coefficients_integer, in_clause_coefficients_boolean,
               in_seed_load, in_seed, in_out_ready,
        output out_valid, out_busy, out_all_satisfied, out_unsat_count,
               out_clause_index, out_clause_coefficients_integer,
               out_clause_coefficients_boolean
    );
endinterface

// File: rtl/unsat_clause_random_selector.sv
// Sequential random unsatisfied-clause selector for the WalkSAT/MCMC step.
// Latches the satisfied mask, counts unsatisfied clauses, draws a rank from a
// free-running Galois LFSR and scans for the clause of that rank.
module unsat_clause_random_selector #(
    parameter int                      CLAUSE_INDEX_WIDTH   = 3,
    parameter int                      INT_COEFF_WIDTH      = 4,
    parameter int                      INT_VAR_INDEX_WIDTH  = 1,
    parameter int                      BOOL_VAR_INDEX_WIDTH = 1,
    parameter int                      LFSR_WIDTH           = 24,
    parameter logic [LFSR_WIDTH-1:0]   LFSR_SEED            = 24'hACE1,
    // x^24 + x^23 + x^22 + x^17 + 1, maximal length for the default width
    parameter logic [LFSR_WIDTH-1:0]   LFSR_TAPS            = 24'hE10000
) (
    input logic                          in_clk,
    input logic                          in_reset,
    unsat_clause_random_selector_if.slave bus
);
    localparam int N      = 1 << CLAUSE_INDEX_WIDTH;
    localparam int INT_W  = ((1 << INT_VAR_INDEX_WIDTH) + 1) * INT_COEFF_WIDTH;
    localparam int BOOL_W = 2 * (1 << BOOL_VAR_INDEX_WIDTH);
    localparam int CW     = CLAUSE_INDEX_WIDTH + 1;   // count width, 0..N
    localparam int RW     = CLAUSE_INDEX_WIDTH + 8;   // rank width
    localparam int PW     = RW + CW;                  // rank*count product width

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                    r_state;
    logic [LFSR_WIDTH-1:0]         r_lfsr;
    logic [N-1:0]                  r_mask;
    logic [N*INT_W-1:0]            r_coeff_int;
    logic [N*BOOL_W-1:0]           r_coeff_bool;
    logic [CW-1:0]                 r_target;
    logic [CLAUSE_INDEX_WIDTH-1:0] r_ptr;
    logic                          r_valid;
    logic                          r_busy;
    logic                          r_all_sat;
    logic [CW-1:0]                 r_unsat_count;
    logic [CLAUSE_INDEX_WIDTH-1:0] r_index;
    logic [INT_W-1:0]              r_out_int;
    logic [BOOL_W-1:0]             r_out_bool;

    logic [LFSR_WIDTH-1:0]         w_lfsr_next;
    logic [CW-1:0]                 w_cnt;
    logic [PW-1:0]                 w_product;
    logic [CW-1:0]                 w_target;
    logic [INT_W-1:0]              w_int_arr  [N];
    logic [BOOL_W-1:0]             w_bool_arr [N];

    // Per-clause views of the latched coefficient vectors for the scan mux
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_clause
            assign w_int_arr[gi]  = r_coeff_int[gi*INT_W +: INT_W];
            assign w_bool_arr[gi] = r_coeff_bool[gi*BOOL_W +: BOOL_W];
        end
    endgenerate

    // Right-shifting Galois step
    assign w_lfsr_next = {1'b0, r_lfsr[LFSR_WIDTH-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);

    // Unsatisfied count and scaled rank: target = (R*cnt) >> RW lies in 0..cnt-1
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt = w_cnt + CW'(r_mask[i] ? 0 : 1);
        end
        w_product = PW'(r_lfsr[RW-1:0]) * PW'(w_cnt);
        w_target  = CW'(w_product >> RW);
    end

    // LFSR runs every edge; a seed load wins and a zero seed falls back to the default
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (bus.in_seed_load) begin
            r_lfsr <= (bus.in_seed == '0) ? LFSR_SEED : bus.in_seed;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Selection FSM with registered result outputs
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            r_state       <= S_IDLE;
            r_mask        <= '0;
            r_coeff_int   <= '0;
            r_coeff_bool  <= '0;
            r_target      <= '0;
            r_ptr         <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_all_sat     <= 1'b0;
            r_unsat_count <= '0;
            r_index       <= '0;
            r_out_int     <= '0;
            r_out_bool    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_start && bus.in_all_checkers_ready) begin
                        r_mask       <= bus.in_clause_satisfied;
                        r_coeff_int  <= bus.in_clause_coefficients_integer;
                        r_coeff_bool <= bus.in_clause_coefficients_boolean;
                        r_busy       <= 1'b1;
                        r_state      <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    r_unsat_count <= w_cnt;
                    r_target      <= w_target;
                    r_ptr         <= '0;
                    if (w_cnt == '0) begin
                        r_valid    <= 1'b1;
                        r_all_sat  <= 1'b1;
                        r_index    <= '0;
                        r_out_int  <= '0;
                        r_out_bool <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!r_mask[r_ptr] && r_target == '0) begin
                        r_valid    <= 1'b1;
                        r_all_sat  <= 1'b0;
                        r_index    <= r_ptr;
                        r_out_int  <= w_int_arr[r_ptr];
                        r_out_bool <= w_bool_arr[r_ptr];
                        r_state    <= S_DONE;
                    end else begin
                        if (!r_mask[r_ptr]) begin
                            r_target <= r_target - CW'(1);
                        end
                        r_ptr <= r_ptr + CLAUSE_INDEX_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here, even on the accept edge
                    if (bus.in_out_ready) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid                       = r_valid;
    assign bus.out_busy                        = r_busy;
    assign bus.out_all_satisfied               = r_all_sat;
    assign bus.out_unsat_count                 = r_unsat_count;
    assign bus.out_clause_index                = r_index;
    assign bus.out_clause_coefficients_integer = r_out_int;
    assign bus.out_clause_coefficients_boolean = r_out_bool;
endmodule

// File: tb/tb_unsat_clause_random_selector.sv
// Self-checking bench for unsat_clause_random_selector: scoreboard of expected
// selections, latency, hold-while-stalled, reset abort, distribution and seeding.
module tb_unsat_clause_random_selector;
    localparam int N      = 8;
    localparam int INT_W  = 12;
    localparam int BOOL_W = 4;

    typedef struct {
        logic [N-1:0]        mask;
        logic [N*INT_W-1:0]  ci;
        logic [N*BOOL_W-1:0] cb;
        int                  cnt;
        int                  fixed_idx;
        int                  e1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   hist[N];
    int   seq_a[10];
    int   seq_b[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unsat_clause_random_selector_if #(
        .CLAUSE_INDEX_WIDTH(3), .INT_COEFF_WIDTH(4), .INT_VAR_INDEX_WIDTH(1),
        .BOOL_VAR_INDEX_WIDTH(1), .LFSR_WIDTH(24)
    ) bus ();

    unsat_clause_random_selector dut (
        .in_clk   (clk),
        .in_reset (rst),
        .bus      (bus.slave)
    );

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic randomize_coeffs();
        for (int i = 0; i < N; i++) begin
            bus.in_clause_coefficients_integer[i*INT_W +: INT_W] = INT_W'($urandom);
            bus.in_clause_coefficients_boolean[i*BOOL_W +: BOOL_W] = BOOL_W'($urandom);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_value({tag, "_valid"}, bus.out_valid, 0);
        check_value({tag, "_busy"},  bus.out_busy, 0);
        check_value({tag, "_allsat"}, bus.out_all_satisfied, 0);
        check_value({tag, "_count"}, bus.out_unsat_count, 0);
        check_value({tag, "_index"}, bus.out_clause_index, 0);
        check_value({tag, "_int"},   bus.out_clause_coefficients_integer, 0);
        check_value({tag, "_bool"},  bus.out_clause_coefficients_boolean, 0);
    endtask

    task automatic check_result(input exp_t e, input int idx);
        check_value("valid", bus.out_valid, 1);
        check_value("busy", bus.out_busy, 1);
        check_value("all_sat", bus.out_all_satisfied, (e.cnt == 0));
        check_value("unsat_count", bus.out_unsat_count, e.cnt);
        if (e.cnt == 0) begin
            check_value("index_sat", bus.out_clause_index, 0);
            check_value("int_sat", bus.out_clause_coefficients_integer, 0);
            check_value("bool_sat", bus.out_clause_coefficients_boolean, 0);
        end else begin
            check_value("pick_unsat", e.mask[idx], 0);
            check_value("int_coeff", bus.out_clause_coefficients_integer, e.ci[idx*INT_W +: INT_W]);
            check_value("bool_coeff", bus.out_clause_coefficients_boolean, e.cb[idx*BOOL_W +: BOOL_W]);
            if (e.fixed_idx >= 0) check_value("index", idx, e.fixed_idx);
        end
    endtask

    // One full transaction: drive start, wait for the result, optionally stall, then accept
    task automatic run_select(input logic [N-1:0] mask, input bit use_c5, input logic [INT_W-1:0] c5,
                              input int hold, input int gap, output int idx);
        exp_t e;
        bit   got;
        int   lat;
        idx = -1;
        @(negedge clk);
        bus.in_clause_satisfied = mask;
        randomize_coeffs();
        if (use_c5) bus.in_clause_coefficients_integer[5*INT_W +: INT_W] = c5;
        e.mask = mask;
        e.ci = bus.in_clause_coefficients_integer;
        e.cb = bus.in_clause_coefficients_boolean;
        e.cnt = 0;
        e.fixed_idx = -1;
        for (int i = 0; i < N; i++) if (!mask[i]) begin e.cnt++; e.fixed_idx = i; end
        if (e.cnt != 1) e.fixed_idx = -1;
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        e.e1 = cyc;
        bus.in_start = 1'b0;
        sb.push_back(e);
        // inputs moving after the start edge must not disturb the selection
        bus.in_clause_satisfied = N'($urandom);
        randomize_coeffs();
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        if (!got) begin
            check_value("valid_timeout", 0, 1);
            return;
        end
        idx = int'(bus.out_clause_index);
        lat = cyc - e.e1;
        check_value("latency", lat, (e.cnt == 0) ? 1 : idx + 2);
        check_result(e, idx);
        $display("[TB] sel mask=%h cnt=%0d idx=%0d lat=%0d", mask, e.cnt, idx, lat);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.in_start = ~bus.in_start;
            bus.in_clause_satisfied = N'($urandom);
            randomize_coeffs();
            @(posedge clk); #1;
            check_result(e, idx);
            check_value("hold_index", bus.out_clause_index, idx);
        end
        @(negedge clk);
        bus.in_out_ready = 1'b1;
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_out_ready = 1'b0;
        bus.in_start = 1'b0;
        check_value("accept_valid", bus.out_valid, 0);
        check_value("accept_busy", bus.out_busy, 0);
        check_value("accept_count_held", bus.out_unsat_count, e.cnt);
        repeat (gap) @(posedge clk);
    endtask

    task automatic load_seed(input logic [23:0] s);
        @(negedge clk);
        bus.in_seed_load = 1'b1;
        bus.in_seed = s;
        @(posedge clk); #1;
        bus.in_seed_load = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        bus.in_start = 1'b0;
        bus.in_all_checkers_ready = 1'b1;
        bus.in_clause_satisfied = '0;
        bus.in_clause_coefficients_integer = '0;
        bus.in_clause_coefficients_boolean = '0;
        bus.in_seed_load = 1'b0;
        bus.in_seed = '0;
        bus.in_out_ready = 1'b0;
        for (int i = 0; i < N; i++) hist[i] = 0;

        repeat (3) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 check_zero_outputs("post_reset");

        // start ignored while checkers are not ready
        @(negedge clk);
        bus.in_all_checkers_ready = 1'b0;
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        bus.in_all_checkers_ready = 1'b1;
        @(posedge clk); #1;
        check_value("not_ready_busy", bus.out_busy, 0);

        // all satisfied, then single unsatisfied clause 5
        run_select(8'hFF, 1'b0, '0, 0, 1, idx);
        run_select(8'b1101_1111, 1'b1, 12'h3A5, 0, 1, idx);

        // long stall with toggling inputs
        run_select(8'b1111_1011, 1'b0, '0, 20, 0, idx);
        run_select(8'b0000_0000, 1'b0, '0, 0, 0, idx);

        // reset in the middle of a scan for clause 7
        @(negedge clk);
        bus.in_clause_satisfied = 8'b0111_1111;
        bus.in_start = 1'b1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_value("pre_abort_busy", bus.out_busy, 1);
        rst = 1'b1;
        #1 check_zero_outputs("abort");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 check_zero_outputs("abort_idle");
        run_select(8'b0111_1111, 1'b0, '0, 0, 1, idx);

        // distribution over unsatisfied {1,3,6}
        for (int t = 0; t < 3000; t++) begin
            run_select(8'b1011_0101, 1'b0, '0, 0, $urandom_range(0, 7), idx);
            if (idx >= 0) hist[idx]++;
        end
        for (int i = 0; i < N; i++) begin
            if (i == 1 || i == 3 || i == 6)
                check_value($sformatf("dist_%0d_in_range(%0d)", i, hist[i]), (hist[i] >= 900 && hist[i] <= 1100), 1);
            else
                check_value($sformatf("dist_%0d_never", i), hist[i], 0);
        end

        // repeatable sequences from a loaded seed
        load_seed(24'h00BEEF);
        for (int t = 0; t < 10; t++) run_select(8'b1011_0101, 1'b0, '0, 0, 2, seq_a[t]);
        load_seed(24'h00BEEF);
        for (int t = 0; t < 10; t++) run_select(8'b1011_0101, 1'b0, '0, 0, 2, seq_b[t]);
        for (int t = 0; t < 10; t++) check_value($sformatf("seed_repeat_%0d", t), seq_b[t], seq_a[t]);

        // zero seed falls back to the default seed
        load_seed(24'h000000);
        for (int t = 0; t < 10; t++) run_select(8'b1011_0101, 1'b0, '0, 0, 2, seq_a[t]);
        load_seed(24'h00ACE1);
        for (int t = 0; t < 10; t++) run_select(8'b1011_0101, 1'b0, '0, 0, 2, seq_b[t]);
        for (int t = 0; t < 10; t++) check_value($sformatf("seed_zero_%0d", t), seq_a[t], seq_b[t]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
